shift_issue_stage: RTL and testbench
====================================

# shift_issue_stage

Execute-stage front end for the datapath's shift instructions. Accepts decoded shift operations through a valid/ready handshake and resolves the shift amount from an immediate or a register. Drives the existing combinational `shifter`, handles the shift amount ≥ 32 cases, and buffers results in a 2-entry output queue for the write-back stage. Sits between decode/register-read and write-back; it is the only producer of `shifter` inputs.

## Interface
- `WIDTH`, 32: data width. Only 32 is supported.
- `TAG_W`, 5: width of the destination-register tag carried with each operation.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid operation.
- `in_ready`  out  1  stage can accept. Registered; no combinational path from `out_ready`.
- `in_op`  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 100 SLLV, 101 SRLV, 110 SRAV. 011 and 111 are illegal.
- `in_data`  in  WIDTH  operand to be shifted.
- `in_rs`  in  WIDTH  shift-amount source for variable ops (`in_op[2]=1`).
- `in_imm`  in  5  shift amount for immediate ops.
- `in_tag`  in  TAG_W  destination tag, passed through unchanged.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  WIDTH  shift result.
- `out_tag`  out  TAG_W  tag of the result.
- `out_err`  out  1  illegal opcode. `out_data` is 0 when this is set.
- `out_zero`  out  1  `out_data == 0`.

## Operation
- **Accept:** an operation is accepted when `in_valid && in_ready` at a rising edge.
- **Shift amount:**
  - Immediate ops use `{27'b0, in_imm}`.
  - Variable ops with `in_rs[31:5]==0` use `{27'b0, in_rs[4:0]}`.
- **`shifter` controls:** `direction=1` means left. `a_or_l=1` means arithmetic, and is set only for SRA/SRAV.
- **Overflow (variable op, `in_rs[31:5]!=0`):** the `shifter` output is bypassed.
  - SLLV and SRLV give 0.
  - SRAV gives `{32{in_data[31]}}`.
- **Illegal op:** `out_data=0`, `out_err=1`, `out_zero=1`. The tag is still passed through and the entry still occupies a queue slot.
- **Output queue:** 2-entry in-order FIFO holding `{data, tag, err, zero}`.
  - Head drives the `out_*` ports.
  - Pop on `out_valid && out_ready`.
  - Push on input accept.
- **Ready:**
  - `in_ready = (count != 2)`, computed from registered count.
  - A pop in the same cycle does not raise `in_ready` until the next cycle.
- **Simultaneous push and pop:**
  - At count=1: count stays 1, the new entry becomes the head next cycle.
  - At count=0: pop is impossible; push gives count=1.
- **Stall stability:** while `out_valid && !out_ready`, all `out_*` stay stable.
- **Reset:** count=0 and both FIFO slots are cleared.

## Timing
- **Latency:** operation accepted at edge T appears on `out_*` with `out_valid=1` after edge T, i.e. 1 cycle. There is no stage register before the queue; the `shifter` and overflow logic sit between the input and the FIFO write.
- **Throughput:** 1 op/cycle with `out_ready` held high (count oscillates 0→1 and stays at 1).
- **Backpressure:** with `out_ready=0` from empty, two accepts fill the queue. `in_ready` goes low the cycle after the second accept.
- **Reset values:**
  - During `rst` and for the edge it is sampled: `in_ready=0`, `out_valid=0`, `out_data=0`, `out_tag=0`, `out_err=0`, `out_zero=0`.
  - `in_ready=1` in the first cycle after `rst` deasserts.
- **Reset mid-operation:** a synchronous `rst` discards all queued entries. No output handshake completes in that cycle.
- **Pointer wrap:** read and write pointers are 1 bit each and wrap 1→0. count is 2 bits; values 0..2 are legal, 3 is unreachable.

## Structure
- **Package `shift_pkg`:**
  - `WIDTH` and `TAG_W` defaults.
  - Opcode constants `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_SLLV`, `OP_SRLV`, `OP_SRAV`.
  - Field positions `OP_VAR_BIT=2`.
  - Queue entry struct/width.
- **Sub-modules:**
  - The existing `shifter` is instantiated unmodified.
  - The 2-entry queue is a separate sub-module, `shift_out_fifo`, parameterised on entry width.

## Test plan
- **SLL immediate:** `in_data=4567` (0x000011D7), `in_op=000`, `in_imm=4`, `out_ready=1` → one cycle later `out_data=0x00011D70`, `out_zero=0`, tag echoed.
- **SRL/SRA immediate:** `in_data=0xFFFFFFC0` (-64), `in_imm=4`.
  - SRL → `0x0FFFFFFC`.
  - SRA → `0xFFFFFFFC`.
  - Back-to-back, one result per cycle, in order.
- **Variable overflow:**
  - SRAV, `in_data=0x80000000`, `in_rs=40` → `0xFFFFFFFF`.
  - SRLV, `in_rs=32` → 0 with `out_zero=1`.
  - SLLV, `in_rs=31`, `in_data=1` → `0x80000000`.
- **Backpressure:** hold `out_ready=0` and present 3 ops with tags 1, 2, 3.
  - Tags 1 and 2 accepted, `in_ready=0`, tag 3 held.
  - Raise `out_ready`: outputs 1, 2, 3 in order; `in_ready` returns the cycle after the first pop.
- **Illegal op:** `in_op=011`, `in_data=0x1234` → `out_err=1`, `out_data=0`, `out_zero=1`. The following legal op has `out_err=0`.
- **Reset mid-operation:** two entries queued, assert `rst` one cycle → `out_valid=0`, all outputs 0, `in_ready=0` during reset and 1 the next cycle. No stale entry reappears.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants, opcode encodings and queue entry layout for the shift issue stage.
package shift_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int TAG_W_DEF  = 5;
  localparam int OP_VAR_BIT = 2;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b100;
  localparam logic [2:0] OP_SRLV = 3'b101;
  localparam logic [2:0] OP_SRAV = 3'b110;

  // Queue entry at default widths; the top packs the same field order.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic [TAG_W_DEF-1:0] tag;
    logic                 err;
    logic                 zero;
  } shift_entry_t;

  localparam int ENTRY_W_DEF = $bits(shift_entry_t);

  // Low opcode bits 11 are unused encodings in both immediate and variable forms.
  function automatic logic op_illegal(input logic [2:0] op);
    return op[1:0] == 2'b11;
  endfunction
endpackage

// File: rtl/shift_out_fifo.sv
// Two-entry in-order result queue with a registered ready flag.
module shift_out_fifo #(
  parameter int EW = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [EW-1:0] i_din,
  input  logic          i_pop,
  output logic [EW-1:0] o_dout,
  output logic          o_valid,
  output logic          o_ready
);
  logic [EW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic          r_rdy;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_cnt_nxt;

  // Push is only honoured when a slot is free; pop only when non-empty.
  assign w_push = i_push && r_rdy;
  assign w_pop  = i_pop && (r_cnt != 2'd0);

  // Next occupancy; ready is registered from it so a pop raises ready one cycle later.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Storage, 1-bit wrapping pointers, count and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_valid = (r_cnt != 2'd0);
  assign o_ready = r_rdy;
endmodule

// File: rtl/shifter.sv
// Existing combinational barrel shifter: left, logical right or arithmetic right.
module shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [4:0]       i_shamt,
  input  logic             i_direction,  // 1 = left
  input  logic             i_a_or_l,     // 1 = arithmetic (right only)
  output logic [WIDTH-1:0] o_result
);
  // Select shift flavour.
  always_comb begin
    o_result = '0;
    if (i_direction)   o_result = i_data << i_shamt;
    else if (i_a_or_l) o_result = $signed(i_data) >>> i_shamt;
    else               o_result = i_data >> i_shamt;
  end
endmodule

// File: rtl/shift_issue_stage.sv
// Shift execute front end: resolves shift amount, drives the shifter,
// handles out-of-range variable shifts and queues results for write-back.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [4:0]       in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             out_zero
);
  localparam int EW = WIDTH + TAG_W + 2;

  logic             w_var;
  logic             w_ovf;
  logic             w_err;
  logic             w_left;
  logic             w_arith;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_sh_out;
  logic [WIDTH-1:0] w_result;
  logic [EW-1:0]    w_din;
  logic [EW-1:0]    w_dout;

  assign w_var   = in_op[OP_VAR_BIT];
  assign w_err   = op_illegal(in_op);
  assign w_shamt = w_var ? in_rs[4:0] : in_imm;
  assign w_ovf   = w_var && (|in_rs[WIDTH-1:5]);
  assign w_left  = (in_op[1:0] == 2'b00);
  assign w_arith = (in_op[1:0] == 2'b10);

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_data      (in_data),
    .i_shamt     (w_shamt),
    .i_direction (w_left),
    .i_a_or_l    (w_arith),
    .o_result    (w_sh_out)
  );

  // Illegal ops force zero; amounts >= 32 bypass the shifter with fill bits.
  always_comb begin
    w_result = w_sh_out;
    if (w_err)      w_result = '0;
    else if (w_ovf) w_result = w_arith ? {WIDTH{in_data[WIDTH-1]}} : '0;
  end

  assign w_din = {w_result, in_tag, w_err, (w_result == '0)};

  shift_out_fifo #(.EW(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_din   (w_din),
    .i_pop   (out_ready),
    .o_dout  (w_dout),
    .o_valid (out_valid),
    .o_ready (in_ready)
  );

  assign {out_data, out_tag, out_err, out_zero} = w_dout;
endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage.
module tb_shift_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [31:0] in_rs;
  logic [4:0]  in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic        out_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_rs     (in_rs),
    .in_imm    (in_imm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .out_zero  (out_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [31:0] rs,
                       input logic [4:0] imm, input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_data = d; in_rs = rs; in_imm = imm; in_tag = tag;
  endtask

  task automatic chk_out(input string name, input logic [31:0] d, input logic [4:0] tag,
                         input logic err, input logic zero);
    chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, ".data"},  out_data, d);
    chk({name, ".tag"},   {27'b0, out_tag}, {27'b0, tag});
    chk({name, ".err"},   {31'b0, out_err}, {31'b0, err});
    chk({name, ".zero"},  {31'b0, out_zero}, {31'b0, zero});
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".in_ready"},  {31'b0, in_ready}, 32'd0);
    chk({name, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, ".out_data"},  out_data, 32'd0);
    chk({name, ".out_tag"},   {27'b0, out_tag}, 32'd0);
    chk({name, ".out_err"},   {31'b0, out_err}, 32'd0);
    chk({name, ".out_zero"},  {31'b0, out_zero}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_data = '0; in_rs = '0;
    in_imm = '0; in_tag = '0; out_ready = 1'b0;
    step(); step();
    chk_reset("reset");
    rst = 1'b0;
    step();
    chk("post_reset.in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_reset.out_valid", {31'b0, out_valid}, 32'd0);

    // Immediate shifts, back to back with out_ready high.
    out_ready = 1'b1;
    drive(3'b000, 32'h0000_11D7, 32'd0, 5'd4, 5'd5);
    step(); chk_out("sll_imm", 32'h0001_1D70, 5'd5, 1'b0, 1'b0);
    drive(3'b001, 32'hFFFF_FFC0, 32'd0, 5'd4, 5'd6);
    step(); chk_out("srl_imm", 32'h0FFF_FFFC, 5'd6, 1'b0, 1'b0);
    drive(3'b010, 32'hFFFF_FFC0, 32'd0, 5'd4, 5'd7);
    step(); chk_out("sra_imm", 32'hFFFF_FFFC, 5'd7, 1'b0, 1'b0);
    chk("throughput.in_ready", {31'b0, in_ready}, 32'd1);

    // Variable shifts including out-of-range amounts.
    drive(3'b110, 32'h8000_0000, 32'd40, 5'd0, 5'd8);
    step(); chk_out("srav_ovf", 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b0);
    drive(3'b101, 32'h8000_0000, 32'd32, 5'd0, 5'd9);
    step(); chk_out("srlv_ovf", 32'h0000_0000, 5'd9, 1'b0, 1'b1);
    drive(3'b100, 32'h0000_0001, 32'd31, 5'd0, 5'd10);
    step(); chk_out("sllv_31", 32'h8000_0000, 5'd10, 1'b0, 1'b0);
    drive(3'b100, 32'h0000_0003, 32'h0000_0040, 5'd0, 5'd11);
    step(); chk_out("sllv_ovf64", 32'h0000_0000, 5'd11, 1'b0, 1'b1);
    drive(3'b101, 32'hF000_0000, 32'd4, 5'd31, 5'd12);
    step(); chk_out("srlv_rs_not_imm", 32'h0F00_0000, 5'd12, 1'b0, 1'b0);

    // Illegal op then a legal op.
    drive(3'b011, 32'h0000_1234, 32'd0, 5'd1, 5'd13);
    step(); chk_out("illegal", 32'h0000_0000, 5'd13, 1'b1, 1'b1);
    drive(3'b000, 32'h0000_1234, 32'd0, 5'd0, 5'd14);
    step(); chk_out("after_illegal", 32'h0000_1234, 5'd14, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: fill the queue, hold a third op.
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_0111, 32'd0, 5'd0, 5'd1);
    step();
    chk_out("bp.t1", 32'h0000_0111, 5'd1, 1'b0, 1'b0);
    chk("bp.rdy_after1", {31'b0, in_ready}, 32'd1);
    drive(3'b000, 32'h0000_0222, 32'd0, 5'd0, 5'd2);
    step();
    chk("bp.rdy_full", {31'b0, in_ready}, 32'd0);
    drive(3'b000, 32'h0000_0333, 32'd0, 5'd0, 5'd3);
    step();
    chk_out("bp.stall_head", 32'h0000_0111, 5'd1, 1'b0, 1'b0);
    chk("bp.rdy_held", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk_out("bp.t2", 32'h0000_0222, 5'd2, 1'b0, 1'b0);
    chk("bp.rdy_back", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp.t3", 32'h0000_0333, 5'd3, 1'b0, 1'b0);
    step();
    chk("bp.empty", {31'b0, out_valid}, 32'd0);

    // Reset with two entries queued.
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_0AAA, 32'd0, 5'd0, 5'd17);
    step();
    drive(3'b000, 32'h0000_0BBB, 32'd0, 5'd0, 5'd18);
    step();
    in_valid = 1'b0;
    chk("rst_mid.full", {31'b0, in_ready}, 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    chk_reset("rst_mid");
    rst = 1'b0;
    step();
    chk("rst_mid.in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("rst_mid.no_stale", {31'b0, out_valid}, 32'd0);
    step();
    chk("rst_mid.no_stale2", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
